// File: rtl/hssi_lpbk_xbar_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hssi_lpbk_pkg : shared types and lane-routing helper for hssi_lpbk_xbar
// Revision: 1.0
// ---------------------------------------------------------------------------
package hssi_lpbk_pkg;

  typedef enum logic [1:0] {
    STRAIGHT  = 2'd0,
    ROTATE    = 2'd1,
    PORT_SWAP = 2'd2,
    SQUELCH   = 2'd3
  } lpbk_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } lpbk_state_e;

  localparam int DROP_CNT_W = 16;

  // Source TX lane feeding destination RX lane 'lane'; SQUELCH routes straight.
  function automatic int lpbk_src_lane(lpbk_mode_e mode, int lane, int num_ports,
                                       int lanes_per_port);
    int src;
    case (mode)
      ROTATE:    src = (lane + 1) % (num_ports * lanes_per_port);
      PORT_SWAP: src = (((lane / lanes_per_port) + 1) % num_ports) * lanes_per_port
                       + (lane % lanes_per_port);
      default:   src = lane;
    endcase
    return src;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hssi_lpbk_xbar_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hssi_lpbk_xbar_if : bench-side bus of the loopback crossbar
// Optional error-injection signals exist only with HSSI_LPBK_ERR_INJ_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface hssi_lpbk_xbar_if
  import hssi_lpbk_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int LANES_PER_PORT = 4,
  parameter int DW             = 64,
  parameter int MAX_DELAY      = 16
);
  localparam int NUM_LANES = NUM_PORTS * LANES_PER_PORT;
  localparam int DLY_W     = $clog2(MAX_DELAY);

  logic                    enable;
  logic                    cfg_load;
  logic [1:0]              cfg_mode;
  logic [DLY_W-1:0]        cfg_delay;
  logic [NUM_LANES-1:0]    tx_valid;
  logic [NUM_LANES*DW-1:0] tx_data;
  logic [NUM_LANES-1:0]    rx_valid;
  logic [NUM_LANES*DW-1:0] rx_data;
  logic                    link_up;
  logic                    cfg_busy;
  logic [DROP_CNT_W-1:0]   drop_cnt;
`ifdef HSSI_LPBK_ERR_INJ_EN
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  logic                    err_inj;
  logic [LANE_W-1:0]       err_lane;
  logic [DROP_CNT_W-1:0]   err_cnt;
`endif

  modport master (
    output enable, cfg_load, cfg_mode, cfg_delay, tx_valid, tx_data,
`ifdef HSSI_LPBK_ERR_INJ_EN
    output err_inj, err_lane,
    input  err_cnt,
`endif
    input  rx_valid, rx_data, link_up, cfg_busy, drop_cnt
  );

  modport slave (
    input  enable, cfg_load, cfg_mode, cfg_delay, tx_valid, tx_data,
`ifdef HSSI_LPBK_ERR_INJ_EN
    input  err_inj, err_lane,
    output err_cnt,
`endif
    output rx_valid, rx_data, link_up, cfg_busy, drop_cnt
  );

endinterface
`default_nettype wire

// File: rtl/hssi_lpbk_xbar_dly_line.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hssi_lpbk_dly_line : one lane's valid/data shift register, variable tap
// Revision: 1.0
// ---------------------------------------------------------------------------
module hssi_lpbk_dly_line #(
  parameter int DW        = 64,
  parameter int MAX_DELAY = 16,
  parameter int DLY_W     = $clog2(MAX_DELAY)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             flush_i,
  input  wire logic             in_valid_i,
  input  wire logic [DW-1:0]    in_data_i,
  input  wire logic [DLY_W-1:0] tap_i,
  output logic                  out_valid_o,
  output logic      [DW-1:0]    out_data_o
);

  logic [MAX_DELAY-1:0] vld_q;
  logic [DW-1:0]        dat_q [MAX_DELAY];

  // Stage 0 is the registered mux stage, so tap 0 yields one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < MAX_DELAY; i++) dat_q[i] <= '0;
    end else begin
      vld_q    <= flush_i ? '0 : {vld_q[MAX_DELAY-2:0], in_valid_i};
      dat_q[0] <= in_data_i;
      for (int i = 1; i < MAX_DELAY; i++) dat_q[i] <= dat_q[i-1];
    end
  end

  assign out_valid_o = vld_q[tap_i];
  assign out_data_o  = dat_q[tap_i];

endmodule
`default_nettype wire

// File: rtl/hssi_lpbk_xbar.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hssi_lpbk_xbar : clocked lane-loopback crossbar with drain-safe reconfig
// Optional: HSSI_LPBK_ERR_INJ_EN adds bit-0 error injection on one lane.
// Revision: 1.0
// ---------------------------------------------------------------------------
module hssi_lpbk_xbar
  import hssi_lpbk_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int LANES_PER_PORT = 4,
  parameter int DW             = 64,
  parameter int MAX_DELAY      = 16
) (
  input wire logic        clk,
  input wire logic        rst_n,
  hssi_lpbk_xbar_if.slave bus
);

  localparam int NUM_LANES = NUM_PORTS * LANES_PER_PORT;
  localparam int DLY_W     = $clog2(MAX_DELAY);
  localparam int CNT_W     = DLY_W + 1;

  lpbk_state_e           state_q, state_d;
  lpbk_mode_e            mode_q, mode_d;
  logic [DLY_W-1:0]      dly_q, dly_d;
  logic [CNT_W-1:0]      drain_cnt_q, drain_cnt_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  flush;
  logic                  run;
  logic [DROP_CNT_W:0]   drop_sum;

  logic [NUM_LANES-1:0]    in_vld;
  logic [NUM_LANES-1:0]    rx_vld;
  logic [NUM_LANES*DW-1:0] rx_dat;

  assign run = (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    dly_d       = dly_q;
    drain_cnt_d = drain_cnt_q;
    flush       = 1'b0;
    // Config is captured in every state; enable=0 still takes priority for state.
    if (bus.cfg_load) begin
      mode_d = lpbk_mode_e'(bus.cfg_mode);
      dly_d  = bus.cfg_delay;
    end
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d     = DRAIN;
          drain_cnt_d = {1'b0, dly_d} + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (!bus.enable) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (bus.cfg_load) begin
          drain_cnt_d = {1'b0, dly_d} + CNT_W'(1);
          flush       = 1'b1;
        end else if (drain_cnt_q <= CNT_W'(1)) begin
          state_d     = RUN;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        if (!bus.enable) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (bus.cfg_load) begin
          state_d     = DRAIN;
          drain_cnt_d = {1'b0, dly_d} + CNT_W'(1);
          flush       = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        flush   = 1'b1;
      end
    endcase
  end

  always_comb begin
    drop_sum = {1'b0, drop_q};
    for (int i = 0; i < NUM_LANES; i++) begin
      drop_sum = drop_sum + (DROP_CNT_W+1)'(bus.tx_valid[i]);
    end
    drop_d = drop_q;
    if (!run) begin
      drop_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= STRAIGHT;
      dly_q       <= '0;
      drain_cnt_q <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      dly_q       <= dly_d;
      drain_cnt_q <= drain_cnt_d;
      drop_q      <= drop_d;
    end
  end

`ifdef HSSI_LPBK_ERR_INJ_EN
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                  err_pend_q, err_pend_d;
  logic [LANE_W-1:0]     err_lane_q, err_lane_d;
  logic [DROP_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [NUM_LANES-1:0]  inj;

  always_comb begin
    err_pend_d = err_pend_q;
    err_lane_d = err_lane_q;
    err_cnt_d  = err_cnt_q;
    if (|inj) begin
      err_pend_d = 1'b0;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + DROP_CNT_W'(1);
    end
    if (run && bus.err_inj) begin
      err_pend_d = 1'b1;
      err_lane_d = bus.err_lane;
    end
    if (state_d != RUN) err_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pend_q <= 1'b0;
      err_lane_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      err_pend_q <= err_pend_d;
      err_lane_q <= err_lane_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam int SRC_ROT = lpbk_src_lane(ROTATE, l, NUM_PORTS, LANES_PER_PORT);
    localparam int SRC_PSW = lpbk_src_lane(PORT_SWAP, l, NUM_PORTS, LANES_PER_PORT);

    logic          src_vld;
    logic [DW-1:0] src_dat;
    logic [DW-1:0] lane_dat;
    logic          out_vld;
    logic [DW-1:0] out_dat;

    always_comb begin
      case (mode_q)
        ROTATE: begin
          src_vld = bus.tx_valid[SRC_ROT];
          src_dat = bus.tx_data[SRC_ROT*DW +: DW];
        end
        PORT_SWAP: begin
          src_vld = bus.tx_valid[SRC_PSW];
          src_dat = bus.tx_data[SRC_PSW*DW +: DW];
        end
        default: begin
          src_vld = bus.tx_valid[l];
          src_dat = bus.tx_data[l*DW +: DW];
        end
      endcase
    end

    assign in_vld[l] = src_vld & run;

`ifdef HSSI_LPBK_ERR_INJ_EN
    assign inj[l]   = err_pend_q && (err_lane_q == LANE_W'(l)) && in_vld[l] && !flush;
    assign lane_dat = src_dat ^ {{(DW-1){1'b0}}, inj[l]};
`else
    assign lane_dat = src_dat;
`endif

    hssi_lpbk_dly_line #(
      .DW        (DW),
      .MAX_DELAY (MAX_DELAY),
      .DLY_W     (DLY_W)
    ) u_dly (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .in_valid_i  (in_vld[l]),
      .in_data_i   (lane_dat),
      .tap_i       (dly_q),
      .out_valid_o (out_vld),
      .out_data_o  (out_dat)
    );

    assign rx_vld[l]             = out_vld & run & (mode_q != SQUELCH);
    assign rx_dat[l*DW +: DW]    = out_dat;
  end

  assign bus.rx_valid = rx_vld;
  assign bus.rx_data  = rx_dat;
  assign bus.link_up  = run;
  assign bus.cfg_busy = (state_q == DRAIN);
  assign bus.drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: doc/hssi_lpbk_xbar.md
Name: hssi_lpbk_xbar

Overview:
- Parametrised, clocked lane-loopback crossbar for HSSI simulation benches. Replaces fixed hard-wired tx-to-rx loopback assigns.
- Routes per-lane parallel TX words back to RX lanes using a runtime-selectable mapping mode, with a programmable per-lane latency.
- Provides link-up/drain control so the mapping can change mid-simulation without corrupting in-flight data.
- Sits between the MAC-side serial/parallel interface and the bench, one instance per HSSI subsystem.

Parameters:
- NUM_PORTS, 2, number of QSFP ports.
- LANES_PER_PORT, 4, lanes per port.
- DW, 64, data width per lane (bits).
- MAX_DELAY, 16, depth of per-lane delay line (must be power of two, ≥2).
- Derived localparams: NUM_LANES = NUM_PORTS*LANES_PER_PORT; DLY_W = $clog2(MAX_DELAY).

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  loopback enable.
- cfg_load  in  1  single-cycle pulse; captures cfg_mode/cfg_delay.
- cfg_mode  in  2  0=STRAIGHT, 1=ROTATE, 2=PORT_SWAP, 3=SQUELCH.
- cfg_delay  in  DLY_W  extra latency cycles.
- tx_valid  in  NUM_LANES  per-lane TX word valid.
- tx_data  in  NUM_LANES*DW  lane l at [l*DW +: DW].
- rx_valid  out  NUM_LANES  per-lane RX word valid.
- rx_data  out  NUM_LANES*DW  routed RX words.
- link_up  out  1  high only in RUN.
- cfg_busy  out  1  high in DRAIN.
- drop_cnt  out  16  saturating count of TX valid beats discarded.

Behaviour:
- Reset values: rx_valid=0, rx_data=0, link_up=0, cfg_busy=0, drop_cnt=0, active mode=STRAIGHT, active delay=0, state=IDLE, all delay-line valids=0.
- Mapping (source lane s for destination lane l, port p=l/LANES_PER_PORT, k=l%LANES_PER_PORT):
  - STRAIGHT: s=l.
  - ROTATE: s=(l+1) mod NUM_LANES.
  - PORT_SWAP: s=((p+1) mod NUM_PORTS)*LANES_PER_PORT+k.
  - SQUELCH: rx_valid forced 0; rx_data still routed per STRAIGHT.
- Latency: tx word in cycle N appears on rx in cycle N+1+active_delay. Registered mux stage, then a shift-register delay line of depth MAX_DELAY with the tap selected by active_delay.
- FSM states and transitions:
  - IDLE: rx_valid=0, link_up=0. On enable=1, go to DRAIN with counter=active_delay+1.
  - DRAIN: cfg_busy=1, link_up=0, rx_valid masked to 0, input valids gated off. Counter decrements each cycle; at 0, go to RUN.
  - RUN: link_up=1, data flows.
    - cfg_load: capture cfg, flush all delay-line valids, go to DRAIN with counter=new_delay+1.
    - enable=0: go to IDLE next cycle and flush valids.
- Counter width is DLY_W+1.
- Drop counting: drop_cnt += popcount(tx_valid) every cycle not in RUN. Saturates at 16'hFFFF. Cleared only by reset.
- Boundary cases:
  - cfg_load in DRAIN: restart drain with the new cfg.
  - cfg_load in IDLE: capture cfg, stay IDLE.
  - cfg_load together with enable=0: capture cfg, go to IDLE (enable wins).
  - cfg_delay=0: latency exactly 1.
  - rst_n asserted mid-operation: all state returns to reset values immediately (async); no rx_valid pulse on deassert.
  - Simultaneous valid on all lanes: no backpressure, every word delivered in RUN.

Optional Feature:
- Macro HSSI_LPBK_ERR_INJ_EN adds inputs err_inj (1) and err_lane (clog2(NUM_LANES)).
- With the macro: an err_inj pulse in RUN inverts bit 0 of the next valid word entering the delay line for err_lane. Output err_cnt (16, saturating) counts injections actually applied. A pending injection is cancelled on leaving RUN.
- Without the macro: the ports and logic are absent; data passes unmodified.

Decomposition:
- Shared package hssi_lpbk_pkg holds:
  - enum lpbk_mode_e {STRAIGHT, ROTATE, PORT_SWAP, SQUELCH}.
  - enum lpbk_state_e {IDLE, DRAIN, RUN}.
  - DROP_CNT_W=16.
  - function lpbk_src_lane(mode, lane, NUM_PORTS, LANES_PER_PORT).
- One sub-module, hssi_lpbk_dly_line: one lane's variable-tap valid/data shift register with a flush input. Instantiated NUM_LANES times by generate.

Test Plan:
- Reset, enable=1, default cfg, drive tx lane3=64'hA5 at cycle N: link_up high after 1 cycle of DRAIN; rx lane3 = 64'hA5 at N+1.
- cfg_load mode=ROTATE, delay=5; drive lane0=1, lane1=2: cfg_busy high 6 cycles, then rx lane0=2 and rx lane7=1, each 6 cycles after send.
- PORT_SWAP with all 8 lanes valid=lane index: rx lane k=tx lane k+4 and vice versa; no drops.
- Drive tx_valid=8'hFF for 10 cycles while enable=0: drop_cnt=80, rx_valid stays 0; preload drop_cnt to 16'hFFFE, then 8 beats → saturates at 16'hFFFF.
- cfg_load in RUN with words in flight (delay=7), then cfg_load again during DRAIN: no rx_valid from pre-change data; drain restarts; RUN resumes after new_delay+1 cycles.
- HSSI_LPBK_ERR_INJ_EN: err_inj with err_lane=2, tx lane2=64'h0: rx lane2=64'h1, err_cnt=1; err_inj in IDLE leaves err_cnt=0.
